// File: rtl/sccpu_dmem_bridge_pkg.sv
// rtl/sccpu_dmem_bridge_pkg.sv - shared state encoding and fault causes for the data-memory bridge
package sccpu_dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_BUSERR   = 2'b10;
    localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

endpackage

// File: rtl/sccpu_dmem_bridge_timeout_cnt.sv
// rtl/sccpu_dmem_bridge_timeout_cnt.sv - loadable saturating wait counter with clear and terminal count
module dmem_timeout_cnt
    import sccpu_dmem_bridge_pkg::*;
#(
    parameter int W  = 5,
    parameter int TC = 15
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic         tc
);

    localparam logic [W-1:0] TC_V  = W'(TC);
    localparam logic [W-1:0] SAT_V = {W{1'b1}};

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != SAT_V)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_V);

endmodule

// File: rtl/sccpu_dmem_bridge.sv
// rtl/sccpu_dmem_bridge.sv - data-memory access stage: req/ack bus master that stalls the CPU per access
module sccpu_dmem_bridge
    import sccpu_dmem_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              wmem,
    input  logic              rmem,
    output logic [31:0]       mem,
    output logic              stall,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic [31:0]       bus_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t      state;
    logic [31:0] rdata_q;
    logic        acc;
    logic        aligned;
    logic        start;
    logic        waiting;
    logic        tc;

    assign acc     = wmem | rmem;
    assign aligned = (addr[1:0] == 2'b00);
    assign start   = (state == IDLE) && acc && aligned;
    assign waiting = (state == REQ) && !bus_ack && !bus_err && !tc;

    // Gated by reset so the CPU is released the instant reset hits, even with an access still presented.
    assign stall = !reset && (start || (state == REQ));
    assign mem   = rdata_q;

    dmem_timeout_cnt #(
        .W  (CW),
        .TC (TIMEOUT - 1)
    ) u_timeout_cnt (
        .clock    (clock),
        .reset    (reset),
        .clr      (start),
        .load     (1'b0),
        .load_val ({CW{1'b0}}),
        .inc      (waiting),
        .tc       (tc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
            rdata_q    <= '0;
        end else begin
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bus_we    <= wmem;
                        bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        bus_wdata <= wdata;
                        bus_req   <= 1'b1;
                        state     <= REQ;
                    end else if (acc) begin
                        fault      <= 1'b1;
                        fault_code <= FLT_MISALIGN;
                    end
                end
                REQ: begin
                    if (bus_err) begin
                        fault      <= 1'b1;
                        fault_code <= FLT_BUSERR;
                        bus_req    <= 1'b0;
                        state      <= DONE;
                    end else if (bus_ack) begin
                        if (!bus_we) begin
                            rdata_q <= bus_rdata;
                        end
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end else if (tc) begin
                        fault      <= 1'b1;
                        fault_code <= FLT_TIMEOUT;
                        bus_req    <= 1'b0;
                        state      <= DONE;
                    end
                end
                // The CPU retires the instruction at this edge; accepting here would re-issue it.
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccpu_dmem_bridge.sv
// tb/tb_sccpu_dmem_bridge.sv - directed self-checking bench for sccpu_dmem_bridge
module tb_sccpu_dmem_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wmem = 1'b0;
    logic        rmem = 1'b0;
    logic [31:0] mem;
    logic        stall;
    logic        fault;
    logic [1:0]  fault_code;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = '0;

    int checks = 0;
    int errors = 0;

    sccpu_dmem_bridge #(
        .ADDR_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .addr       (addr),
        .wdata      (wdata),
        .wmem       (wmem),
        .rmem       (rmem),
        .mem        (mem),
        .stall      (stall),
        .fault      (fault),
        .fault_code (fault_code),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_err    (bus_err),
        .bus_rdata  (bus_rdata)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // reset state
        tick();
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_mem", mem, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // aligned load, ack in first REQ cycle
        rmem = 1'b1; addr = 32'h100;
        #1;
        check("ld_idle_stall", 32'(stall), 32'd1);
        check("ld_idle_req", 32'(bus_req), 32'd0);
        tick();
        check("ld_req", 32'(bus_req), 32'd1);
        check("ld_addr", bus_addr, 32'h100);
        check("ld_we", 32'(bus_we), 32'd0);
        check("ld_req_stall", 32'(stall), 32'd1);
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        tick();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        check("ld_done_req", 32'(bus_req), 32'd0);
        check("ld_done_stall", 32'(stall), 32'd0);
        check("ld_done_mem", mem, 32'hDEADBEEF);
        check("ld_done_fault", 32'(fault), 32'd0);
        tick();
        check("ld_no_reissue", 32'(bus_req), 32'd0);
        rmem = 1'b0;
        tick();

        // store with three wait cycles
        wmem = 1'b1; addr = 32'h204; wdata = 32'h12345678;
        #1;
        check("st_idle_stall", 32'(stall), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("st_req%0d", i), 32'(bus_req), 32'd1);
            check($sformatf("st_we%0d", i), 32'(bus_we), 32'd1);
            check($sformatf("st_wdata%0d", i), bus_wdata, 32'h12345678);
            check($sformatf("st_addr%0d", i), bus_addr, 32'h204);
            check($sformatf("st_stall%0d", i), 32'(stall), 32'd1);
            if (i == 3) begin
                bus_ack = 1'b1; bus_rdata = 32'h55555555;
            end
            tick();
        end
        bus_ack = 1'b0; bus_rdata = 32'h0;
        check("st_done_stall", 32'(stall), 32'd0);
        check("st_done_req", 32'(bus_req), 32'd0);
        check("st_mem_kept", mem, 32'hDEADBEEF);
        check("st_done_fault", 32'(fault), 32'd0);
        wmem = 1'b0;
        tick();

        // misaligned load
        rmem = 1'b1; addr = 32'h103;
        #1;
        check("mis_stall", 32'(stall), 32'd0);
        tick();
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_code", 32'(fault_code), 32'd1);
        check("mis_no_req", 32'(bus_req), 32'd0);
        rmem = 1'b0;
        tick();
        check("mis_fault_pulse", 32'(fault), 32'd0);
        check("mis_mem", mem, 32'hDEADBEEF);

        // timeout with TIMEOUT = 4
        rmem = 1'b1; addr = 32'h300;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to_req%0d", i), 32'(bus_req), 32'd1);
            check($sformatf("to_nofault%0d", i), 32'(fault), 32'd0);
            tick();
        end
        check("to_fault", 32'(fault), 32'd1);
        check("to_code", 32'(fault_code), 32'd3);
        check("to_req_off", 32'(bus_req), 32'd0);
        check("to_stall", 32'(stall), 32'd0);
        check("to_mem", mem, 32'hDEADBEEF);
        rmem = 1'b0;
        tick();
        check("to_idle_fault", 32'(fault), 32'd0);
        check("to_idle_req", 32'(bus_req), 32'd0);

        // bus error wins over simultaneous ack
        rmem = 1'b1; addr = 32'h400;
        tick();
        bus_err = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        tick();
        bus_err = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
        check("be_fault", 32'(fault), 32'd1);
        check("be_code", 32'(fault_code), 32'd2);
        check("be_mem", mem, 32'hDEADBEEF);
        check("be_req_off", 32'(bus_req), 32'd0);
        rmem = 1'b0;
        tick();

        // reset in the second REQ cycle, then a clean load
        rmem = 1'b1; addr = 32'h500;
        tick();
        tick();
        check("rr_req_before", 32'(bus_req), 32'd1);
        reset = 1'b1;
        #1;
        check("rr_req", 32'(bus_req), 32'd0);
        check("rr_stall", 32'(stall), 32'd0);
        check("rr_mem", mem, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check("rr_after_fault", 32'(fault), 32'd0);
        tick();
        check("rr_new_req", 32'(bus_req), 32'd1);
        check("rr_new_addr", bus_addr, 32'h500);
        bus_ack = 1'b1; bus_rdata = 32'h0BADCAFE;
        tick();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        check("rr_new_mem", mem, 32'h0BADCAFE);
        check("rr_new_fault", 32'(fault), 32'd0);
        rmem = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
